sdcard_slot_mux: RTL and testbench

//  N-slot SPI SD-card port multiplexer between the service processor SPI master and the board card slots.

---
 rtl/sdcard_slot_mux_pkg.sv | 21 ++
 rtl/sdcard_cd_debounce.sv | 44 ++++
 rtl/sdcard_slot_mux.sv | 148 ++++++++++++++
 tb/tb_sdcard_slot_mux.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdcard_slot_mux_pkg.sv
// Shared definitions for the SD-card slot multiplexer: FSM encoding and bus park levels.
package sdcard_slot_mux_pkg;

  typedef enum logic [1:0] {
    ST_GUARD   = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_PENDING = 2'd2,
    ST_FORCED  = 2'd3
  } state_t;

  // Levels an unrouted slot sees, and what the master sees while nothing is routed.
  localparam logic PARK_CS_N = 1'b1;
  localparam logic PARK_SCK  = 1'b0;
  localparam logic PARK_MOSI = 1'b0;
  localparam logic PARK_MISO = 1'b1;

  function automatic logic is_routed(input state_t s);
    return (s == ST_ACTIVE) || (s == ST_PENDING);
  endfunction

endpackage

// File: rtl/sdcard_cd_debounce.sv
// One-bit card-detect / write-protect conditioner: 2-FF synchroniser followed by a
// stability counter; the output only follows after DEBOUNCE_CYCLES steady cycles.
module sdcard_cd_debounce #(
  parameter int DEBOUNCE_CYCLES = 108000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        // Any return to the accepted level restarts the stability window.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sdcard_slot_mux.sv
// SPI SD-card slot multiplexer: routes one master to one of NUM_SLOTS slots, switching only
// while CS is idle, with a parked guard interval and forced park on card removal.
module sdcard_slot_mux
  import sdcard_slot_mux_pkg::*;
#(
  parameter int NUM_SLOTS       = 2,
  parameter int SEL_BITS        = 1,
  parameter int DEBOUNCE_CYCLES = 108000,
  parameter int GUARD_CYCLES    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_BITS-1:0]   sel_req,
  output logic [SEL_BITS-1:0]   sel_active,
  output logic                  busy,
  input  logic                  spi_cs,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [0:NUM_SLOTS-1]  slot_cs_n,
  output logic [0:NUM_SLOTS-1]  slot_sck,
  output logic [0:NUM_SLOTS-1]  slot_mosi,
  input  logic [0:NUM_SLOTS-1]  slot_miso,
  input  logic [0:NUM_SLOTS-1]  slot_cd_n,
  input  logic [0:NUM_SLOTS-1]  slot_wp,
  output logic [0:NUM_SLOTS-1]  card_present,
  output logic [0:NUM_SLOTS-1]  card_wp,
  output logic                  cd_change
);

  localparam int GCNT_W = $clog2(GUARD_CYCLES + 1);
  localparam logic [GCNT_W-1:0]   GUARD_LOAD = GCNT_W'(GUARD_CYCLES - 1);
  localparam logic [SEL_BITS:0]   SLOT_LIMIT = (SEL_BITS + 1)'(NUM_SLOTS);

  state_t               state;
  state_t               state_nxt;
  logic [SEL_BITS-1:0]  sel_nxt;
  logic [GCNT_W-1:0]    gcnt;
  logic [GCNT_W-1:0]    gcnt_nxt;
  logic [0:NUM_SLOTS-1] present_q;
  logic [0:NUM_SLOTS-1] cd_fall;
  logic                 sel_valid;
  logic                 switch_req;
  logic                 removal;
  logic                 routed;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_detect
    sdcard_cd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cd (
      .clk   (clk),
      .reset (reset),
      .raw   (~slot_cd_n[i]),
      .level (card_present[i])
    );
    sdcard_cd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wp (
      .clk   (clk),
      .reset (reset),
      .raw   (slot_wp[i]),
      .level (card_wp[i])
    );
  end

  // Previous debounced presence gives change/removal edges; both reset to 0 so no reset pulse.
  always_ff @(posedge clk) begin
    if (reset) present_q <= '0;
    else       present_q <= card_present;
  end

  assign cd_change  = |(card_present ^ present_q);
  assign cd_fall    = present_q & ~card_present;
  assign sel_valid  = ({1'b0, sel_req} < SLOT_LIMIT);
  assign switch_req = sel_valid && (sel_req != sel_active);
  assign removal    = cd_fall[sel_active];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_GUARD;
      sel_active <= '0;
      gcnt       <= GUARD_LOAD;
    end else begin
      state      <= state_nxt;
      sel_active <= sel_nxt;
      gcnt       <= gcnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_active;
    gcnt_nxt  = gcnt;
    unique case (state)
      ST_GUARD: begin
        if (gcnt == '0) state_nxt = ST_ACTIVE;
        else            gcnt_nxt  = gcnt - GCNT_W'(1);
      end
      ST_ACTIVE: begin
        // Removal outranks a simultaneous switch request.
        if (removal) begin
          state_nxt = ST_FORCED;
        end else if (switch_req) begin
          if (!spi_cs) begin
            sel_nxt   = sel_req;
            gcnt_nxt  = GUARD_LOAD;
            state_nxt = ST_GUARD;
          end else begin
            state_nxt = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (removal) begin
          state_nxt = ST_FORCED;
        end else if (sel_req == sel_active) begin
          state_nxt = ST_ACTIVE;
        end else if (!spi_cs && sel_valid) begin
          sel_nxt   = sel_req;
          gcnt_nxt  = GUARD_LOAD;
          state_nxt = ST_GUARD;
        end
      end
      ST_FORCED: begin
        if (!spi_cs) begin
          gcnt_nxt  = GUARD_LOAD;
          state_nxt = ST_GUARD;
        end
      end
      default: begin
        state_nxt = ST_GUARD;
        gcnt_nxt  = GUARD_LOAD;
      end
    endcase
  end

  assign busy   = (state != ST_ACTIVE);
  assign routed = is_routed(state);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_route
    logic hit;
    assign hit          = routed && (sel_active == SEL_BITS'(i));
    assign slot_cs_n[i] = hit ? ~spi_cs  : PARK_CS_N;
    assign slot_sck[i]  = hit ? spi_sck  : PARK_SCK;
    assign slot_mosi[i] = hit ? spi_mosi : PARK_MOSI;
  end

  assign spi_miso = routed ? slot_miso[sel_active] : PARK_MISO;

endmodule

// File: tb/tb_sdcard_slot_mux.sv
// Directed bench for sdcard_slot_mux: routing vector table plus guard, pending, debounce
// and forced-park sequences.
module tb_sdcard_slot_mux;

  localparam int NS  = 4;
  localparam int SB  = 3;
  localparam int DEB = 5000;
  localparam int GC  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [SB-1:0] sel_req;
  logic [SB-1:0] sel_active;
  logic          busy;
  logic          spi_cs, spi_sck, spi_mosi, spi_miso;
  logic [0:NS-1] slot_cs_n, slot_sck, slot_mosi, slot_miso;
  logic [0:NS-1] slot_cd_n, slot_wp, card_present, card_wp;
  logic          cd_change;

  int checks   = 0;
  int failures = 0;

  sdcard_slot_mux #(
    .NUM_SLOTS(NS), .SEL_BITS(SB), .DEBOUNCE_CYCLES(DEB), .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk), .reset(reset), .sel_req(sel_req), .sel_active(sel_active), .busy(busy),
    .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .slot_cs_n(slot_cs_n), .slot_sck(slot_sck), .slot_mosi(slot_mosi), .slot_miso(slot_miso),
    .slot_cd_n(slot_cd_n), .slot_wp(slot_wp), .card_present(card_present), .card_wp(card_wp),
    .cd_change(cd_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs, sck, mosi;
    logic [0:3] miso_in;
    logic [0:3] e_cs_n, e_sck, e_mosi;
    logic       e_miso;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      spi_cs    = vecs[i].cs;
      spi_sck   = vecs[i].sck;
      spi_mosi  = vecs[i].mosi;
      slot_miso = vecs[i].miso_in;
      #1;
      check($sformatf("vec%0d_cs_n", i), slot_cs_n, vecs[i].e_cs_n);
      check($sformatf("vec%0d_sck", i),  slot_sck,  vecs[i].e_sck);
      check($sformatf("vec%0d_mosi", i), slot_mosi, vecs[i].e_mosi);
      check($sformatf("vec%0d_miso", i), spi_miso,  vecs[i].e_miso);
      check($sformatf("vec%0d_busy", i), busy,      1'b0);
      step();
    end
  endtask

  // Counts cycles until busy drops while wiggling the master bus; reports any unparked slot.
  task automatic wait_guard(output int n, output logic parked_ok);
    n = 0;
    parked_ok = 1'b1;
    while (busy && n < 200) begin
      spi_sck  = ~spi_sck;
      spi_mosi = ~spi_mosi;
      #1;
      if (slot_cs_n !== 4'b1111 || slot_sck !== 4'b0000 || slot_mosi !== 4'b0000 ||
          spi_miso !== 1'b1)
        parked_ok = 1'b0;
      step();
      n++;
    end
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n, pulses;
    logic ok;

    //              cs    sck   mosi  miso_in   cs_n     sck      mosi     miso
    vecs[0] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 4'b1000, 4'b0111, 4'b0000, 4'b1000, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 4'b0111, 4'b0111, 4'b1000, 4'b0000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b0111, 4'b1000, 4'b1000, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 4'b1000, 4'b1000, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 4'b0010, 4'b1101, 4'b0010, 4'b0010, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 4'b1101, 4'b1101, 4'b0000, 4'b0000, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 4'b0010, 4'b1111, 4'b0000, 4'b0010, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b1101, 4'b0010, 4'b0000, 1'b1};

    reset     = 1'b1;
    sel_req   = '0;
    spi_cs    = 1'b0;
    spi_sck   = 1'b0;
    spi_mosi  = 1'b0;
    slot_miso = 4'b0000;
    slot_cd_n = 4'b1111;
    slot_wp   = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and initial guard
    check("rst_busy", busy, 1'b1);
    check("rst_sel", sel_active, 3'd0);
    check("rst_cs_n", slot_cs_n, 4'b1111);
    check("rst_miso", spi_miso, 1'b1);
    check("rst_present", card_present, 4'b0000);
    check("rst_wp", card_wp, 4'b0000);
    check("rst_cd_change", cd_change, 1'b0);
    wait_guard(n, ok);
    check("rst_guard_len", n, GC);
    check("rst_guard_park", ok, 1'b1);
    check("rst_sel_after", sel_active, 3'd0);

    apply_vecs(0, 4);

    // Out-of-range request is ignored
    sel_req = 3'd5;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      spi_cs = i[0];
      step();
      if (busy !== 1'b0 || sel_active !== 3'd0) ok = 1'b0;
    end
    check("bad_sel_ignored", ok, 1'b1);
    sel_req = 3'd0;
    spi_cs  = 1'b0;
    step();

    // Idle switch 0 -> 2
    sel_req = 3'd2;
    step();
    check("sw_busy", busy, 1'b1);
    check("sw_sel", sel_active, 3'd2);
    wait_guard(n, ok);
    check("sw_guard_len", n, GC);
    check("sw_guard_park", ok, 1'b1);
    apply_vecs(5, 8);

    // Pending switch 2 -> 1 while CS held, abort, then complete
    spi_cs  = 1'b1;
    spi_sck = 1'b0;
    sel_req = 3'd1;
    step();
    check("pend_busy", busy, 1'b1);
    check("pend_sel", sel_active, 3'd2);
    spi_sck = 1'b1;
    #1;
    check("pend_sck", slot_sck, 4'b0010);
    check("pend_cs_n", slot_cs_n, 4'b1101);
    sel_req = 3'd2;
    step();
    check("pend_abort", busy, 1'b0);
    sel_req = 3'd1;
    step();
    check("pend_again", busy, 1'b1);
    spi_cs  = 1'b0;
    spi_sck = 1'b0;
    step();
    check("pend_latch_sel", sel_active, 3'd1);
    check("pend_latch_busy", busy, 1'b1);
    spi_cs = 1'b1;
    wait_guard(n, ok);
    check("pend_guard_len", n, GC);
    check("pend_guard_park", ok, 1'b1);
    #1;
    check("pend_routed_cs_n", slot_cs_n, 4'b1011);

    // Card-detect bounce on slot 1, then steady insertion; WP on slot 3
    slot_wp[3] = 1'b1;
    ok = 1'b1;
    for (int t = 0; t < 10; t++) begin
      slot_cd_n[1] = ~slot_cd_n[1];
      for (int c = 0; c < 1000; c++) begin
        step();
        if (card_present !== 4'b0000 || cd_change !== 1'b0) ok = 1'b0;
      end
    end
    check("bounce_rejected", ok, 1'b1);
    slot_cd_n[1] = 1'b0;
    n = 0;
    pulses = 0;
    while (!card_present[1] && n < 6000) begin
      step();
      n++;
      if (cd_change) pulses++;
    end
    repeat (10) begin
      step();
      if (cd_change) pulses++;
    end
    check("insert_latency", n, DEB + 2);
    check("insert_pulses", pulses, 1);
    check("insert_present", card_present, 4'b0100);
    check("wp_debounced", card_wp, 4'b0001);
    check("insert_busy", busy, 1'b0);

    // Removal of the active card mid-transfer forces park
    slot_miso    = 4'b0000;
    slot_cd_n[1] = 1'b1;
    n = 0;
    pulses = 0;
    while (!busy && n < 6000) begin
      step();
      n++;
      if (cd_change) pulses++;
    end
    check("remove_latency", n, DEB + 3);
    check("remove_pulses", pulses, 1);
    check("remove_present", card_present, 4'b0000);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      spi_sck = ~spi_sck;
      step();
      if (!busy || slot_cs_n !== 4'b1111 || slot_sck !== 4'b0000 || spi_miso !== 1'b1)
        ok = 1'b0;
    end
    check("forced_hold", ok, 1'b1);
    spi_cs  = 1'b0;
    spi_sck = 1'b0;
    step();
    check("forced_exit_busy", busy, 1'b1);
    wait_guard(n, ok);
    check("forced_guard_len", n, GC);
    check("forced_guard_park", ok, 1'b1);
    check("forced_sel_kept", sel_active, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
